btn_debounce: RTL and testbench

Input conditioner for the board push-buttons and VIO button probes, placed in front of the mode and colour-select logic.
- Each channel passes through a 2-FF synchronizer, then a per-channel debounce FSM.
- Outputs per channel: a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Downstream logic (mode mux, colour register) consumes pulses instead of raw levels.

---
 rtl/btn_debounce.sv | 169 ++++++++++++++++
 tb/tb_btn_debounce.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Per-channel push-button conditioner: 2-FF synchronizer, debounce FSM, level plus press/release pulses.
// Optional auto-repeat of the press pulse while held is enabled with BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce #(
  parameter int NB_BTN          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_level,
  output logic [NB_BTN-1:0] o_btn_press,
  output logic [NB_BTN-1:0] o_btn_release
);

  // state     | meaning
  // LOW       | debounced 0, s2 stable low
  // WAIT_HIGH | s2 went high, counting stable-high cycles
  // HIGH      | debounced 1, s2 stable high
  // WAIT_LOW  | s2 went low, counting stable-low cycles (still reported pressed)
  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [NB_BTN-1:0] s1, s2;
  state_t            state     [NB_BTN];
  state_t            state_nxt [NB_BTN];
  logic [CW-1:0]     cnt       [NB_BTN];
  logic [CW-1:0]     cnt_nxt   [NB_BTN];
  logic [NB_BTN-1:0] press_nxt, release_nxt, press_any;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_btn;
      s2 <= s1;
    end
  end

  // The first sample of a new level counts as cycle 1, so a window of one cycle accepts immediately.
  always_comb begin
    for (int i = 0; i < NB_BTN; i++) begin
      state_nxt[i]   = state[i];
      cnt_nxt[i]     = cnt[i];
      press_nxt[i]   = 1'b0;
      release_nxt[i] = 1'b0;
      case (state[i])
        LOW: if (s2[i]) begin
          if (CNT_ONE == CNT_MAX) begin
            state_nxt[i] = HIGH;
            cnt_nxt[i]   = '0;
            press_nxt[i] = 1'b1;
          end else begin
            state_nxt[i] = WAIT_HIGH;
            cnt_nxt[i]   = CNT_ONE;
          end
        end
        WAIT_HIGH: if (!s2[i]) begin
          state_nxt[i] = LOW;
          cnt_nxt[i]   = '0;
        end else if (cnt[i] + CNT_ONE == CNT_MAX) begin
          state_nxt[i] = HIGH;
          cnt_nxt[i]   = '0;
          press_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
        HIGH: if (!s2[i]) begin
          if (CNT_ONE == CNT_MAX) begin
            state_nxt[i]   = LOW;
            cnt_nxt[i]     = '0;
            release_nxt[i] = 1'b1;
          end else begin
            state_nxt[i] = WAIT_LOW;
            cnt_nxt[i]   = CNT_ONE;
          end
        end
        WAIT_LOW: if (s2[i]) begin
          state_nxt[i] = HIGH;
          cnt_nxt[i]   = '0;
        end else if (cnt[i] + CNT_ONE == CNT_MAX) begin
          state_nxt[i]   = LOW;
          cnt_nxt[i]     = '0;
          release_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
        default: begin
          state_nxt[i] = LOW;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0]     rpt     [NB_BTN];
  logic [RW-1:0]     rpt_nxt [NB_BTN];
  logic [NB_BTN-1:0] rpt_pulse;
  logic              held;

  // Down-counter reloaded on each pulse; fires on terminal count 1 while the button stays held.
  always_comb begin
    held = 1'b0;
    for (int i = 0; i < NB_BTN; i++) begin
      rpt_nxt[i]   = rpt[i];
      rpt_pulse[i] = 1'b0;
      held = (state[i] == HIGH || state[i] == WAIT_LOW) && (state_nxt[i] != LOW);
      if (press_nxt[i]) begin
        rpt_nxt[i] = RW'(REPEAT_DELAY);
      end else if (held) begin
        if (rpt[i] == RW'(1)) begin
          rpt_pulse[i] = 1'b1;
          rpt_nxt[i]   = RW'(REPEAT_PERIOD);
        end else if (rpt[i] != '0) begin
          rpt_nxt[i] = rpt[i] - RW'(1);
        end
      end else begin
        rpt_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NB_BTN; i++) begin
      if (reset) rpt[i] <= '0;
      else       rpt[i] <= rpt_nxt[i];
    end
  end

  assign press_any = press_nxt | rpt_pulse;
`else
  assign press_any = press_nxt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      o_btn_press   <= '0;
      o_btn_release <= '0;
    end else begin
      o_btn_press   <= press_any;
      o_btn_release <= release_nxt;
    end
    for (int i = 0; i < NB_BTN; i++) begin
      if (reset) begin
        state[i] <= LOW;
        cnt[i]   <= '0;
      end else begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    o_btn_level = '0;
    for (int i = 0; i < NB_BTN; i++)
      o_btn_level[i] = (state[i] == HIGH) || (state[i] == WAIT_LOW);
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: run-length reference model compared every cycle.
module tb_btn_debounce;
  localparam int NB = 4;
  localparam int D  = 16;
  localparam int RD = 64;
  localparam int RP = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] i_btn;
  logic [NB-1:0] o_btn_level, o_btn_press, o_btn_release;

  btn_debounce #(.NB_BTN(NB), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clock(clock), .reset(reset), .i_btn(i_btn),
    .o_btn_level(o_btn_level), .o_btn_press(o_btn_press), .o_btn_release(o_btn_release));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: output flips once the synchronized input has differed from it for D samples in a row.
  logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_rel;
  int run [NB];
  int age [NB];

  task automatic model_edge();
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      for (int c = 0; c < NB; c++) begin run[c] = 0; age[c] = 0; end
    end else begin
      for (int c = 0; c < NB; c++) begin
        m_press[c] = 1'b0;
        m_rel[c]   = 1'b0;
        if (m_s2[c] != m_level[c]) run[c]++;
        else run[c] = 0;
        if (run[c] == D) begin
          run[c] = 0;
          m_level[c] = ~m_level[c];
          if (m_level[c]) begin m_press[c] = 1'b1; age[c] = 0; end
          else m_rel[c] = 1'b1;
        end else if (m_level[c]) begin
          age[c]++;
`ifdef BTN_DEBOUNCE_REPEAT_EN
          if (age[c] >= RD && (age[c] - RD) % RP == 0) m_press[c] = 1'b1;
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = i_btn;
    end
  endtask

  task automatic tick(input logic [NB-1:0] b, input logic r);
    i_btn = b;
    reset = r;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick(4'hf, 1'b1);
      n_checks++;
      if ({o_btn_level, o_btn_press, o_btn_release} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d got %h required 000", k, {o_btn_level, o_btn_press, o_btn_release});
      end
    end
    for (int k = 0; k < 20; k++) begin
      tick(4'hf, 1'b0);
      n_checks++;
      if ({o_btn_level, o_btn_press, o_btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL reset_release k=%0d got %h required %h", k,
                 {o_btn_level, o_btn_press, o_btn_release}, {m_level, m_press, m_rel});
      end
      if (k == 17) begin
        n_checks++;
        if (o_btn_press !== 4'hf || o_btn_level !== 4'hf) begin
          n_fail++;
          $display("FAIL reset_first_press got press=%h level=%h required f f", o_btn_press, o_btn_level);
        end
      end
    end
  endtask

  task automatic test_single_press();
    tick(4'h0, 1'b1);
    tick(4'h0, 1'b1);
    for (int k = 0; k < 25; k++) begin
      tick(4'h1, 1'b0);
      n_checks++;
      if ({o_btn_level, o_btn_press, o_btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL single_press k=%0d got %h required %h", k,
                 {o_btn_level, o_btn_press, o_btn_release}, {m_level, m_press, m_rel});
      end
      if (k == 16 || k == 17 || k == 18) begin
        n_checks++;
        if (o_btn_press !== ((k == 17) ? 4'h1 : 4'h0)) begin
          n_fail++;
          $display("FAIL single_press_edge k=%0d got press=%h", k, o_btn_press);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int presses = 0;
    logic [NB-1:0] b;
    for (int k = 0; k < 80; k++) begin
      b = 4'h1;
      b[1] = (k >= 40) ? 1'b1 : ~(k / 5) % 2 == 0 ? 1'b1 : 1'b0;
      b[1] = (k >= 40) ? 1'b1 : (((k / 5) % 2) == 0);
      tick(b, 1'b0);
      if (o_btn_press[1]) presses++;
      n_checks++;
      if ({o_btn_level, o_btn_press, o_btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL bounce k=%0d got %h required %h", k,
                 {o_btn_level, o_btn_press, o_btn_release}, {m_level, m_press, m_rel});
      end
    end
    n_checks++;
    if (presses != 1) begin
      n_fail++;
      $display("FAIL bounce_press_count got %0d required 1", presses);
    end
  endtask

  task automatic test_glitch();
    int rels = 0;
    for (int k = 0; k < 110; k++) begin
      tick({1'b0, (k < 30 || (k >= 40 && k < 70)) ? 1'b1 : 1'b0, 2'b11}, 1'b0);
      if (o_btn_release[2]) rels++;
      n_checks++;
      if ({o_btn_level, o_btn_press, o_btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL glitch k=%0d got %h required %h", k,
                 {o_btn_level, o_btn_press, o_btn_release}, {m_level, m_press, m_rel});
      end
    end
    n_checks++;
    if (rels != 1 || o_btn_level[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_release got count=%0d level=%b required 1 0", rels, o_btn_level[2]);
    end
  endtask

  task automatic test_reset_mid();
    tick(4'h0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      tick(4'h8, (k == 12 || k == 13) ? 1'b1 : 1'b0);
      n_checks++;
      if ({o_btn_level, o_btn_press, o_btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d got %h required %h", k,
                 {o_btn_level, o_btn_press, o_btn_release}, {m_level, m_press, m_rel});
      end
    end
  endtask

  task automatic test_repeat();
    int presses = 0;
    int exp_presses;
    tick(4'h0, 1'b1);
    for (int k = 0; k < 260; k++) begin
      tick({3'b000, (k < 218) ? 1'b1 : 1'b0}, 1'b0);
      if (o_btn_press[0]) presses++;
      n_checks++;
      if ({o_btn_level, o_btn_press, o_btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL repeat k=%0d got %h required %h", k,
                 {o_btn_level, o_btn_press, o_btn_release}, {m_level, m_press, m_rel});
      end
    end
    // Press pulse at edge 17, release accepted at edge 235: offsets 0, 64..208 step 16.
`ifdef BTN_DEBOUNCE_REPEAT_EN
    exp_presses = 11;
`else
    exp_presses = 1;
`endif
    n_checks++;
    if (presses != exp_presses) begin
      n_fail++;
      $display("FAIL repeat_count got %0d required %0d", presses, exp_presses);
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] b = '0;
    int hold [NB];
    for (int c = 0; c < NB; c++) hold[c] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold[c] == 0) begin
          b[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 28);
        end else hold[c]--;
      end
      tick(b, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
      n_checks++;
      if ({o_btn_level, o_btn_press, o_btn_release} !== {m_level, m_press, m_rel}) begin
        n_fail++;
        $display("FAIL random k=%0d got %h required %h", k,
                 {o_btn_level, o_btn_press, o_btn_release}, {m_level, m_press, m_rel});
      end
    end
  endtask

  initial begin
    i_btn = '0;
    reset = 1'b1;
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < NB; c++) begin run[c] = 0; age[c] = 0; end
    test_reset();
    test_single_press();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
